// File: rtl/gba_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gba_mem_pkg
// Description : Shared memory-map definitions for the CPU bus wait-state
//               logic: region enum, access sizes, N-wait table, WAITCNT
//               register address and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package gba_mem_pkg;

    typedef enum logic [3:0] {
        REGION_BIOS     = 4'd0,
        REGION_EWRAM    = 4'd1,
        REGION_IWRAM    = 4'd2,
        REGION_IO       = 4'd3,
        REGION_PAL      = 4'd4,
        REGION_VRAM     = 4'd5,
        REGION_OAM      = 4'd6,
        REGION_WS0      = 4'd7,
        REGION_WS1      = 4'd8,
        REGION_WS2      = 4'd9,
        REGION_SRAM     = 4'd10,
        REGION_UNMAPPED = 4'd11
    } region_e;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
    localparam logic [1:0] MEM_SIZE_RESR = 2'd3;

    // Non-sequential wait counts selected by a 2-bit WAITCNT field
    localparam logic [4:0] N_TABLE_0 = 5'd4;
    localparam logic [4:0] N_TABLE_1 = 5'd3;
    localparam logic [4:0] N_TABLE_2 = 5'd2;
    localparam logic [4:0] N_TABLE_3 = 5'd8;

    localparam logic [31:0] WAITCNT_ADDR = 32'h0400_0204;

    function automatic logic [4:0] n_wait(input logic [1:0] idx);
        case (idx)
            2'd0:    return N_TABLE_0;
            2'd1:    return N_TABLE_1;
            2'd2:    return N_TABLE_2;
            default: return N_TABLE_3;
        endcase
    endfunction

    function automatic region_e decode_region(input logic [31:0] addr);
        if (addr[31:28] != 4'h0) begin
            return REGION_UNMAPPED;
        end
        case (addr[27:24])
            4'h0:        return REGION_BIOS;
            4'h2:        return REGION_EWRAM;
            4'h3:        return REGION_IWRAM;
            4'h4:        return REGION_IO;
            4'h5:        return REGION_PAL;
            4'h6:        return REGION_VRAM;
            4'h7:        return REGION_OAM;
            4'h8, 4'h9:  return REGION_WS0;
            4'hA, 4'hB:  return REGION_WS1;
            4'hC, 4'hD:  return REGION_WS2;
            4'hE, 4'hF:  return REGION_SRAM;
            default:     return REGION_UNMAPPED;
        endcase
    endfunction

    // RESR is treated like a word access
    function automatic logic [31:0] access_bytes(input logic [1:0] size);
        case (size)
            MEM_SIZE_BYTE: return 32'd1;
            MEM_SIZE_HALF: return 32'd2;
            default:       return 32'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws_calc.sv
`default_nettype none
// ============================================================================
// Module      : ws_calc
// Description : Combinational wait-state calculator. Decodes the region,
//               classifies ROM accesses as sequential/non-sequential and
//               produces the total number of stall cycles for an access.
// Revision    : 1.0 - initial release
// ============================================================================
module ws_calc
    import gba_mem_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [10:0] waitcnt,
    input  logic        prev_valid,
    input  logic [31:0] prev_addr,
    input  logic [1:0]  prev_size,
    input  region_e     prev_region,
    output region_e     region,
    output logic        seq,
    output logic [4:0]  total
);

    logic       w_is_rom;
    logic       w_contig;
    logic       w_is16;
    logic [4:0] w_n;
    logic [4:0] w_s;
    logic [4:0] w_first;
    logic [4:0] w_second;

    assign region   = decode_region(addr);
    assign w_is_rom = (region == REGION_WS0) || (region == REGION_WS1) ||
                      (region == REGION_WS2);

    // A 128 KiB boundary restarts the ROM burst, so it is never sequential
    assign w_contig = prev_valid && (prev_region == region) &&
                      (addr == prev_addr + access_bytes(prev_size)) &&
                      (addr[16:0] != 17'd0);
    assign seq      = w_is_rom && w_contig;

    // Per-region first/second-half waits and the resulting total
    always_comb begin
        w_is16   = 1'b0;
        w_n      = 5'd0;
        w_s      = 5'd0;
        w_first  = 5'd0;
        w_second = 5'd0;
        case (region)
            REGION_EWRAM: begin
                w_is16   = 1'b1;
                w_first  = 5'd2;
                w_second = 5'd2;
            end
            REGION_PAL, REGION_VRAM: begin
                w_is16 = 1'b1;
            end
            REGION_WS0: begin
                w_is16 = 1'b1;
                w_n    = n_wait(waitcnt[3:2]);
                w_s    = waitcnt[4] ? 5'd1 : 5'd2;
            end
            REGION_WS1: begin
                w_is16 = 1'b1;
                w_n    = n_wait(waitcnt[6:5]);
                w_s    = waitcnt[7] ? 5'd1 : 5'd4;
            end
            REGION_WS2: begin
                w_is16 = 1'b1;
                w_n    = n_wait(waitcnt[9:8]);
                w_s    = waitcnt[10] ? 5'd1 : 5'd8;
            end
            REGION_SRAM: begin
                w_first = n_wait(waitcnt[1:0]);
            end
            default: begin
                w_first = 5'd0;
            end
        endcase
        // The second half of a split ROM word always continues the burst
        if (w_is_rom) begin
            w_first  = seq ? w_s : w_n;
            w_second = w_s;
        end
        // size[1] covers WORD and RESR
        if (w_is16 && size[1]) begin
            total = w_first + 5'd1 + w_second;
        end else begin
            total = w_first;
        end
    end

endmodule
`default_nettype wire

// File: rtl/waitstate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : waitstate_ctrl
// Description : CPU bus wait-state controller. Accepts an access whenever
//               the bus is not paused, stalls the CPU for the computed
//               number of wait cycles, owns the WAITCNT register and flags
//               writes to read-only regions.
// Revision    : 1.0 - initial release
// ============================================================================
module waitstate_ctrl
    import gba_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic        pause,
    output logic        abort,
    output logic [15:0] waitcnt,
    output logic        seq
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;

    logic [15:0] r_waitcnt;
    logic        r_seq;
    logic        r_prev_valid;
    logic [31:0] r_prev_addr;
    logic [1:0]  r_prev_size;
    region_e     r_prev_region;
    logic        r_wc_lo_pend;
    logic        r_wc_hi_pend;
    logic        r_abort_pend;

    region_e     w_region;
    logic        w_seq;
    logic [4:0]  w_total;
    logic        w_wc_lo_hit;
    logic        w_wc_hi_hit;
    logic        w_illegal_wr;
    logic        w_unused_wdata;

    ws_calc u_ws_calc (
        .addr        (addr),
        .size        (size),
        .waitcnt     (r_waitcnt[10:0]),
        .prev_valid  (r_prev_valid),
        .prev_addr   (r_prev_addr),
        .prev_size   (r_prev_size),
        .prev_region (r_prev_region),
        .region      (w_region),
        .seq         (w_seq),
        .total       (w_total)
    );

    // Byte-lane decode of a WAITCNT write; misaligned forms are ignored
    assign w_wc_lo_hit  = write && (addr == WAITCNT_ADDR);
    assign w_wc_hi_hit  = write &&
                          (((addr == WAITCNT_ADDR) && (size != MEM_SIZE_BYTE)) ||
                           ((addr == WAITCNT_ADDR + 32'd1) && (size == MEM_SIZE_BYTE)));
    assign w_illegal_wr = write && ((w_region == REGION_BIOS) || (w_region == REGION_WS0) ||
                                    (w_region == REGION_WS1)  || (w_region == REGION_WS2));

    // WAITCNT is 15 bits wide; the upper data bits have no destination
    assign w_unused_wdata = ^wdata[31:15];

    // State register and wait down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: an IDLE cycle is an accept; WAIT counts down to zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_total != 5'd0) begin
                    w_state_nxt = c_ST_WAIT;
                    w_cnt_nxt   = w_total;
                end
            end
            default: begin
                if (r_cnt <= 5'd1) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 5'd1;
                end
            end
        endcase
    end

    // Accept-edge bookkeeping: the data cycle of the previous access ends on
    // this same edge, so pending WAITCNT lanes commit here before any newly
    // accepted write re-arms them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waitcnt     <= 16'h0000;
            r_seq         <= 1'b0;
            r_prev_valid  <= 1'b0;
            r_prev_addr   <= 32'd0;
            r_prev_size   <= MEM_SIZE_BYTE;
            r_prev_region <= REGION_UNMAPPED;
            r_wc_lo_pend  <= 1'b0;
            r_wc_hi_pend  <= 1'b0;
            r_abort_pend  <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            if (r_wc_lo_pend) begin
                r_waitcnt[7:0] <= wdata[7:0];
            end
            if (r_wc_hi_pend) begin
                r_waitcnt[14:8] <= wdata[14:8];
            end
            r_wc_lo_pend  <= w_wc_lo_hit;
            r_wc_hi_pend  <= w_wc_hi_hit;
            r_abort_pend  <= w_illegal_wr;
            r_seq         <= w_seq;
            r_prev_valid  <= 1'b1;
            r_prev_addr   <= addr;
            r_prev_size   <= size;
            r_prev_region <= w_region;
        end
    end

    assign pause   = (r_state == c_ST_WAIT);
    assign abort   = r_abort_pend && !pause;
    assign waitcnt = r_waitcnt;
    assign seq     = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_waitstate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_waitstate_ctrl
// Description : Directed self-checking bench for waitstate_ctrl. Each task
//               drives one scenario and compares against hand-computed
//               stall counts, seq, abort and WAITCNT values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_waitstate_ctrl;
    import gba_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        write;
    logic [31:0] wdata;
    logic        pause;
    logic        abort;
    logic [15:0] waitcnt;
    logic        seq;

    int checks = 0;
    int errors = 0;

    waitstate_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .size    (size),
        .write   (write),
        .wdata   (wdata),
        .pause   (pause),
        .abort   (abort),
        .waitcnt (waitcnt),
        .seq     (seq)
    );

    always #5 clk = ~clk;

    // Present one access at a negedge, let it be accepted, then count the
    // stalled cycles. Returns at the negedge of the data cycle.
    task automatic do_acc(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                          input logic [31:0] wd, output int pcyc, output logic sq,
                          output int ab_wait, output logic ab_data);
        addr  = a;
        size  = sz;
        write = wr;
        @(posedge clk);
        @(negedge clk);
        wdata   = wd;
        sq      = seq;
        pcyc    = 0;
        ab_wait = 0;
        while (pause === 1'b1 && pcyc < 40) begin
            pcyc++;
            if (abort !== 1'b0) ab_wait++;
            @(negedge clk);
        end
        checks++;
        if (pause !== 1'b0) begin
            errors++;
            $display("FAIL timeout @%08h: pause=%b after %0d cycles, required 0", a, pause, pcyc);
        end
        ab_data = abort;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        addr  = 32'h0300_0000;
        size  = MEM_SIZE_WORD;
        write = 1'b0;
        wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pause !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b, required 0", pause); end
        checks++;
        if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b, required 0", abort); end
        checks++;
        if (waitcnt !== 16'h0000) begin errors++; $display("FAIL reset_waitcnt: got %04h, required 0000", waitcnt); end
        checks++;
        if (seq !== 1'b0) begin errors++; $display("FAIL reset_seq: got %b, required 0", seq); end
        rst = 1'b0;
    endtask

    task automatic test_first_access;
        int pc, aw; logic sq, ad;
        do_acc(32'h0800_0000, MEM_SIZE_HALF, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 4) begin errors++; $display("FAIL first_half_pause: got %0d, required 4", pc); end
        checks++;
        if (sq !== 1'b0) begin errors++; $display("FAIL first_half_seq: got %b, required 0", sq); end
    endtask

    task automatic test_back_to_back;
        int pc, aw; logic sq, ad;
        do_acc(32'h0800_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 7 || sq !== 1'b0) begin errors++; $display("FAIL b2b_word_n: got %0d/seq%b, required 7/seq0", pc, sq); end
        do_acc(32'h0800_0004, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 5 || sq !== 1'b1) begin errors++; $display("FAIL b2b_word_s: got %0d/seq%b, required 5/seq1", pc, sq); end
        do_acc(32'h0800_0008, MEM_SIZE_HALF, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 2 || sq !== 1'b1) begin errors++; $display("FAIL b2b_half_s: got %0d/seq%b, required 2/seq1", pc, sq); end
    endtask

    task automatic test_boundary;
        int pc, aw; logic sq, ad;
        do_acc(32'h0801_FFFC, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 7 || sq !== 1'b0) begin errors++; $display("FAIL bnd_first: got %0d/seq%b, required 7/seq0", pc, sq); end
        do_acc(32'h0802_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 7 || sq !== 1'b0) begin errors++; $display("FAIL bnd_cross: got %0d/seq%b, required 7/seq0", pc, sq); end
    endtask

    task automatic test_waitcnt_write;
        int pc, aw; logic sq, ad;
        do_acc(32'h0400_0204, MEM_SIZE_HALF, 1'b1, 32'h0000_0014, pc, sq, aw, ad);
        checks++;
        if (pc !== 0 || ad !== 1'b0) begin errors++; $display("FAIL wc_write: got %0d/abort%b, required 0/abort0", pc, ad); end
        do_acc(32'h0300_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (waitcnt !== 16'h0014) begin errors++; $display("FAIL wc_value: got %04h, required 0014", waitcnt); end
        do_acc(32'h0800_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 5 || sq !== 1'b0) begin errors++; $display("FAIL wc_rom_word: got %0d/seq%b, required 5/seq0", pc, sq); end
        // Access accepted on the commit edge still sees the old value
        do_acc(32'h0400_0204, MEM_SIZE_HALF, 1'b1, 32'h0000_0000, pc, sq, aw, ad);
        do_acc(32'h0800_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 5) begin errors++; $display("FAIL wc_commit_edge: got %0d, required 5", pc); end
        checks++;
        if (waitcnt !== 16'h0000) begin errors++; $display("FAIL wc_cleared: got %04h, required 0000", waitcnt); end
        // Byte lanes; bit 15 always reads 0
        do_acc(32'h0400_0204, MEM_SIZE_BYTE, 1'b1, 32'h0000_00AB, pc, sq, aw, ad);
        do_acc(32'h0400_0205, MEM_SIZE_BYTE, 1'b1, 32'h0000_CDCD, pc, sq, aw, ad);
        do_acc(32'h0300_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (waitcnt !== 16'h4DAB) begin errors++; $display("FAIL wc_bytes: got %04h, required 4dab", waitcnt); end
        do_acc(32'h0400_0204, MEM_SIZE_HALF, 1'b1, 32'h0000_0000, pc, sq, aw, ad);
        do_acc(32'h0300_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (waitcnt !== 16'h0000) begin errors++; $display("FAIL wc_restore: got %04h, required 0000", waitcnt); end
    endtask

    task automatic test_abort;
        int pc, aw; logic sq, ad;
        do_acc(32'h0000_0100, MEM_SIZE_WORD, 1'b1, 32'h1234_5678, pc, sq, aw, ad);
        checks++;
        if (pc !== 0 || ad !== 1'b1) begin errors++; $display("FAIL abort_bios: got %0d/abort%b, required 0/abort1", pc, ad); end
        do_acc(32'h0300_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 0 || ad !== 1'b0) begin errors++; $display("FAIL abort_iwram: got %0d/abort%b, required 0/abort0", pc, ad); end
        do_acc(32'h0800_0000, MEM_SIZE_HALF, 1'b1, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 4 || aw !== 0 || ad !== 1'b1) begin
            errors++; $display("FAIL abort_rom: got %0d/inwait%0d/abort%b, required 4/inwait0/abort1", pc, aw, ad);
        end
    endtask

    task automatic test_regions;
        int pc, aw; logic sq, ad;
        do_acc(32'h0200_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 5) begin errors++; $display("FAIL ewram_word: got %0d, required 5", pc); end
        do_acc(32'h0600_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 1) begin errors++; $display("FAIL vram_word: got %0d, required 1", pc); end
        do_acc(32'h0E00_0000, MEM_SIZE_BYTE, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 4 || sq !== 1'b0) begin errors++; $display("FAIL sram_byte: got %0d/seq%b, required 4/seq0", pc, sq); end
        do_acc(32'h0C00_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 13) begin errors++; $display("FAIL ws2_word: got %0d, required 13", pc); end
        do_acc(32'h0A00_0000, MEM_SIZE_HALF, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 4 || sq !== 1'b0) begin errors++; $display("FAIL ws1_n: got %0d/seq%b, required 4/seq0", pc, sq); end
        do_acc(32'h0A00_0002, MEM_SIZE_HALF, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 4 || sq !== 1'b1) begin errors++; $display("FAIL ws1_s: got %0d/seq%b, required 4/seq1", pc, sq); end
        do_acc(32'h1000_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 0) begin errors++; $display("FAIL unmapped: got %0d, required 0", pc); end
    endtask

    task automatic test_reset_seq;
        int pc, aw; logic sq, ad;
        do_acc(32'h0800_0000, MEM_SIZE_HALF, 1'b0, 32'd0, pc, sq, aw, ad);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_acc(32'h0800_0002, MEM_SIZE_HALF, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 4 || sq !== 1'b0) begin errors++; $display("FAIL post_reset_n: got %0d/seq%b, required 4/seq0", pc, sq); end
    endtask

    task automatic test_reset_mid_wait;
        int pc, aw; logic sq, ad;
        do_acc(32'h0400_0204, MEM_SIZE_HALF, 1'b1, 32'h0000_000C, pc, sq, aw, ad);
        do_acc(32'h0300_0000, MEM_SIZE_WORD, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (waitcnt !== 16'h000C) begin errors++; $display("FAIL mid_wc: got %04h, required 000c", waitcnt); end
        addr  = 32'h0800_0000;
        size  = MEM_SIZE_HALF;
        write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pause !== 1'b1) begin errors++; $display("FAIL mid_wait_start: got %b, required 1", pause); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pause !== 1'b0) begin errors++; $display("FAIL mid_reset_pause: got %b, required 0", pause); end
        checks++;
        if (waitcnt !== 16'h0000) begin errors++; $display("FAIL mid_reset_wc: got %04h, required 0000", waitcnt); end
        rst = 1'b0;
        do_acc(32'h0800_0000, MEM_SIZE_HALF, 1'b0, 32'd0, pc, sq, aw, ad);
        checks++;
        if (pc !== 4) begin errors++; $display("FAIL mid_after: got %0d, required 4", pc); end
    endtask

    initial begin
        test_reset;
        test_first_access;
        test_back_to_back;
        test_boundary;
        test_waitcnt_write;
        test_abort;
        test_regions;
        test_reset_seq;
        test_reset_mid_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
